// File: rtl/mem_resp.sv
// mem_resp: word-addressed memory responder sitting behind the BIU
// request/ready handshake. It takes one request at a time (read, write,
// 32-bit instruction fetch), inserts WAIT_STATES wait cycles, accesses an
// internal DEPTH x 16 array and then pulses ready for a single cycle.
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous active-low reset (array contents survive)
//   cs     in   1   request strobe
//   sel    in   2   00 read, 01 write, 10 fetch, 11 reserved (err)
//   addr   in  16   word address, low log2(DEPTH) bits used
//   wdata  in  16   write data
//   rdata  out 16   read data, held until the next read
//   ir     out 32   fetched instruction {mem[a], mem[a+1]}, held until next fetch
//   ready  out  1   one-cycle completion pulse
//   err    out  1   pulses with ready for the reserved operation
//   busy   out  1   high while a transaction is in flight (state != IDLE)
module mem_resp #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [1:0]  sel,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic [31:0] ir,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;
    localparam int unsigned DW = 16;

    // Counter preload; WAIT is skipped entirely when WAIT_STATES is 0.
    localparam logic [CW-1:0] WS_LOAD = (WAIT_STATES == 0) ? CW'(0) : CW'(WAIT_STATES - 1);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FETCH = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_ACCESS = 3'd2,
        S_FETCH2 = 3'd3,
        S_RESP   = 3'd4,
        S_HOLD   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [AW-1:0]   a_q, a_d;
    logic [DW-1:0]   wd_q, wd_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [2*DW-1:0] ir_q, ir_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    logic            mem_we_c;
    logic [AW-1:0]   mem_idx_c;
    logic [DW-1:0]   mem_rd_c;

    logic [DW-1:0]   mem_q [DEPTH];

    // Upper address bits are deliberately ignored.
    if (AW < 16) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr[15:AW];
    end

    // Single read port: second half of a fetch reads the wrapped next word.
    assign mem_rd_c = mem_q[mem_idx_c];

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        wd_d      = wd_q;
        rdata_d   = rdata_q;
        ir_d      = ir_q;
        mem_we_c  = 1'b0;
        mem_idx_c = a_q;

        case (state_q)
            S_IDLE: begin
                if (cs) begin
                    op_d  = sel;
                    a_d   = addr[AW-1:0];
                    wd_d  = wdata;
                    cnt_d = WS_LOAD;
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CW'(0)) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ACCESS: begin
                case (op_q)
                    OP_READ: begin
                        rdata_d = mem_rd_c;
                        state_d = S_RESP;
                    end
                    OP_WRITE: begin
                        mem_we_c = 1'b1;
                        state_d  = S_RESP;
                    end
                    OP_FETCH: begin
                        ir_d[2*DW-1:DW] = mem_rd_c;
                        state_d         = S_FETCH2;
                    end
                    default: begin
                        state_d = S_RESP;
                    end
                endcase
            end
            S_FETCH2: begin
                mem_idx_c     = a_q + AW'(1);
                ir_d[DW-1:0]  = mem_rd_c;
                state_d       = S_RESP;
            end
            S_RESP: begin
                // A still-asserted cs must not re-issue the same request.
                if (cs) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (!cs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_RESP);
        err_d   = (state_d == S_RESP) && (op_q == OP_RSVD);
        busy_d  = (state_d != S_IDLE);
    end

    // Control, operand and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
            ir_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            ir_q    <= ir_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Storage array; intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[a_q] <= wd_q;
        end
    end

    assign rdata = rdata_q;
    assign ir    = ir_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp (DEPTH=256, WAIT_STATES=1).
module tb_mem_resp;

    localparam int DEPTH = 256;
    localparam int WS    = 1;

    logic        clk;
    logic        reset;
    logic        cs;
    logic [1:0]  sel;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [31:0] ir;
    logic        ready;
    logic        err;
    logic        busy;

    int total;
    int bad;

    logic [15:0] model_mem [DEPTH];
    logic [15:0] last_rd;
    logic [31:0] last_ir;

    mem_resp #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk   (clk),
        .reset (reset),
        .cs    (cs),
        .sel   (sel),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ir    (ir),
        .ready (ready),
        .err   (err),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request (cs for one edge, then scramble inputs) and collect the response.
    // Must be entered at posedge+1; leaves at posedge+1 one edge after ready.
    task automatic issue(input logic [1:0] s, input logic [15:0] a, input logic [15:0] d,
                         output int lat, output logic [15:0] rd, output logic [31:0] ins,
                         output logic e, output logic busy0, output logic rdy_after,
                         output logic busy_after);
        cs = 1'b1; sel = s; addr = a; wdata = d;
        @(posedge clk); #1;
        busy0 = busy;
        cs = 1'b0; sel = 2'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
        lat = -1; rd = 'x; ins = 'x; e = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) begin
                lat = n; rd = rdata; ins = ir; e = err;
                break;
            end
        end
        @(posedge clk); #1;
        rdy_after  = ready;
        busy_after = busy;
    endtask

    task automatic test_reset();
        reset = 1'b0; cs = 1'b0; sel = 2'b00; addr = '0; wdata = '0;
        #2;
        total++;
        if ({ready, err, busy} !== 3'b000 || rdata !== 16'h0 || ir !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: rdy/err/busy=%b rdata=%h ir=%h, want 000/0/0",
                     {ready, err, busy}, rdata, ir);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if ({ready, err, busy} !== 3'b000 || rdata !== 16'h0 || ir !== 32'h0) begin
                bad++;
                $display("FAIL idle_after_reset[%0d]: rdy/err/busy=%b rdata=%h ir=%h, want 000/0/0",
                         i, {ready, err, busy}, rdata, ir);
            end
        end
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] rd; logic [31:0] ins; logic e, b0, ra, ba;
        issue(2'b01, 16'h0012, 16'hA5C3, lat, rd, ins, e, b0, ra, ba);
        total++;
        if (lat !== WS + 1 || e !== 1'b0 || b0 !== 1'b1) begin
            bad++;
            $display("FAIL write_resp: lat=%0d err=%b busy0=%b, want %0d/0/1", lat, e, b0, WS + 1);
        end
        total++;
        if (ra !== 1'b0 || ba !== 1'b0) begin
            bad++;
            $display("FAIL write_pulse: ready_after=%b busy_after=%b, want 0/0", ra, ba);
        end
        issue(2'b00, 16'h0012, 16'h0000, lat, rd, ins, e, b0, ra, ba);
        total++;
        if (lat !== WS + 1 || rd !== 16'hA5C3 || e !== 1'b0) begin
            bad++;
            $display("FAIL read_back: lat=%0d rdata=%h err=%b, want %0d/a5c3/0", lat, rd, e, WS + 1);
        end
    endtask

    task automatic test_fetch_wrap();
        int lat; logic [15:0] rd; logic [31:0] ins; logic e, b0, ra, ba;
        issue(2'b01, 16'h00FF, 16'h1234, lat, rd, ins, e, b0, ra, ba);
        issue(2'b01, 16'h0000, 16'h5678, lat, rd, ins, e, b0, ra, ba);
        issue(2'b10, 16'h01FF, 16'h0000, lat, rd, ins, e, b0, ra, ba);
        total++;
        if (lat !== WS + 2 || ins !== 32'h12345678 || e !== 1'b0) begin
            bad++;
            $display("FAIL fetch_wrap: lat=%0d ir=%h err=%b, want %0d/12345678/0", lat, ins, e, WS + 2);
        end
        total++;
        if (rd !== 16'hA5C3) begin
            bad++;
            $display("FAIL fetch_keeps_rdata: rdata=%h, want a5c3", rd);
        end
    endtask

    task automatic test_held_cs();
        int pulses; logic busy_ok;
        pulses = 0; busy_ok = 1'b1;
        cs = 1'b1; sel = 2'b00; addr = 16'h0012;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) pulses++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        total++;
        if (pulses != 1 || busy_ok !== 1'b1 || rdata !== 16'hA5C3) begin
            bad++;
            $display("FAIL held_cs: pulses=%0d busy_always=%b rdata=%h, want 1/1/a5c3",
                     pulses, busy_ok, rdata);
        end
        cs = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL held_cs_release: busy=%b ready=%b, want 0/0", busy, ready);
        end
    endtask

    task automatic test_reserved();
        int lat; logic [15:0] rd; logic [31:0] ins; logic e, b0, ra, ba;
        issue(2'b01, 16'h0030, 16'h3C3C, lat, rd, ins, e, b0, ra, ba);
        issue(2'b11, 16'h0030, 16'hFFFF, lat, rd, ins, e, b0, ra, ba);
        total++;
        if (lat !== WS + 1 || e !== 1'b1 || ra !== 1'b0) begin
            bad++;
            $display("FAIL reserved_err: lat=%0d err=%b ready_after=%b, want %0d/1/0", lat, e, ra, WS + 1);
        end
        issue(2'b00, 16'h0030, 16'h0000, lat, rd, ins, e, b0, ra, ba);
        total++;
        if (rd !== 16'h3C3C || e !== 1'b0) begin
            bad++;
            $display("FAIL reserved_no_write: rdata=%h err=%b, want 3c3c/0", rd, e);
        end
    endtask

    task automatic test_mid_change();
        int lat; logic [15:0] rd; logic [31:0] ins; logic e, b0, ra, ba; logic seen;
        issue(2'b01, 16'h0041, 16'hBEEF, lat, rd, ins, e, b0, ra, ba);
        cs = 1'b1; sel = 2'b01; addr = 16'h0040; wdata = 16'h1111;
        @(posedge clk); #1;
        addr = 16'h0041; wdata = 16'h2222; sel = 2'b10;
        @(posedge clk); #1;
        cs = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b1) begin
            bad++;
            $display("FAIL mid_change_done: ready seen=%b, want 1", seen);
        end
        repeat (2) @(posedge clk);
        #1;
        issue(2'b00, 16'h0040, 16'h0000, lat, rd, ins, e, b0, ra, ba);
        total++;
        if (rd !== 16'h1111) begin
            bad++;
            $display("FAIL mid_change_latched: mem[40]=%h, want 1111", rd);
        end
        issue(2'b00, 16'h0041, 16'h0000, lat, rd, ins, e, b0, ra, ba);
        total++;
        if (rd !== 16'hBEEF) begin
            bad++;
            $display("FAIL mid_change_other: mem[41]=%h, want beef", rd);
        end
    endtask

    task automatic test_reset_mid_write();
        int lat; logic [15:0] rd; logic [31:0] ins; logic e, b0, ra, ba;
        issue(2'b01, 16'h0077, 16'h0F0F, lat, rd, ins, e, b0, ra, ba);
        issue(2'b00, 16'h0077, 16'h0000, lat, rd, ins, e, b0, ra, ba);
        cs = 1'b1; sel = 2'b01; addr = 16'h0077; wdata = 16'hDEAD;
        @(posedge clk); #1;
        cs = 1'b0;
        total++;
        if (busy !== 1'b1 || rdata !== 16'h0F0F) begin
            bad++;
            $display("FAIL pre_reset_state: busy=%b rdata=%h, want 1/0f0f", busy, rdata);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({ready, err, busy} !== 3'b000 || rdata !== 16'h0 || ir !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: rdy/err/busy=%b rdata=%h ir=%h, want 000/0/0",
                     {ready, err, busy}, rdata, ir);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        issue(2'b00, 16'h0077, 16'h0000, lat, rd, ins, e, b0, ra, ba);
        total++;
        if (lat !== WS + 1 || rd !== 16'h0F0F) begin
            bad++;
            $display("FAIL write_aborted: lat=%0d rdata=%h, want %0d/0f0f", lat, rd, WS + 1);
        end
    endtask

    // Random back-to-back traffic against a flat array model.
    task automatic test_back_to_back();
        int lat; logic [15:0] rd; logic [31:0] ins; logic e, b0, ra, ba;
        logic [1:0] op; logic [15:0] a, d; int idx, exp_lat; logic exp_err;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        last_rd = 16'h0; last_ir = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            d = 16'($urandom);
            model_mem[i] = d;
            issue(2'b01, 16'(i) | 16'($urandom_range(0, 255) << 8), d, lat, rd, ins, e, b0, ra, ba);
        end
        for (int t = 0; t < 80; t++) begin
            op = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            d  = 16'($urandom);
            idx = int'(a) % DEPTH;
            exp_lat = WS + 1 + ((op == 2'b10) ? 1 : 0);
            exp_err = (op == 2'b11);
            if (op == 2'b00) last_rd = model_mem[idx];
            if (op == 2'b01) model_mem[idx] = d;
            if (op == 2'b10) last_ir = {model_mem[idx], model_mem[(idx + 1) % DEPTH]};
            issue(op, a, d, lat, rd, ins, e, b0, ra, ba);
            total++;
            if (lat !== exp_lat || e !== exp_err || rd !== last_rd || ins !== last_ir ||
                ra !== 1'b0 || ba !== 1'b0 || b0 !== 1'b1) begin
                bad++;
                $display("FAIL rand[%0d] op=%0d a=%h: lat=%0d err=%b rdata=%h ir=%h rdy/busy_after=%b%b busy0=%b, want %0d/%b/%h/%h/00/1",
                         t, op, a, lat, e, rd, ins, ra, ba, b0, exp_lat, exp_err, last_rd, last_ir);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_read();
        test_fetch_wrap();
        test_held_cs();
        test_reserved();
        test_mid_change();
        test_reset_mid_write();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_resp.md
# mem_resp

Word-addressed memory responder on the far side of the BIU request/ready handshake. It accepts one request at a time (word read, word write, or 32-bit instruction fetch) from the bus interface unit. It inserts a programmable number of wait states, performs the access on an internal array, and signals completion with a one-cycle `ready` pulse. It gives the fetch/execute path a cycle-accurate memory model with back-pressure.

## Interface
- `DEPTH`, 256 — number of 16-bit words; power of two, 16..65536.
- `WAIT_STATES`, 1 — extra cycles inserted before every access; 0..15.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-low. Low clears all state and outputs immediately; release is synchronous to `clk`.
- `cs`  in  1  — request strobe from the initiator.
- `sel`  in  2  — operation: 00 read, 01 write, 10 instruction fetch, 11 reserved.
- `addr`  in  16  — word address; only the low log2(`DEPTH`) bits are used, upper bits ignored.
- `wdata`  in  16  — write data.
- `rdata`  out  16  — read data; valid while `ready`=1 and held until the next read.
- `ir`  out  32  — fetched instruction, {mem[a], mem[a+1]}; valid while `ready`=1 and held until the next fetch.
- `ready`  out  1  — one-cycle completion pulse.
- `err`  out  1  — pulses with `ready` when `sel`=11.
- `busy`  out  1  — high whenever the state is not IDLE.

## Operation
- **States:** IDLE, WAIT, ACCESS, FETCH2, RESP, HOLD.
- **IDLE.** When `cs`=1 at a rising edge:
  - latch `sel`, `addr[log2(DEPTH)-1:0]` (called a) and `wdata`;
  - go to WAIT with counter loaded to `WAIT_STATES`-1, or go straight to ACCESS when `WAIT_STATES`=0.
- **WAIT.** The counter decrements each cycle. At 0, go to ACCESS.
- **ACCESS.** Actions by latched `sel`:
  - read: `rdata`<=mem[a], then RESP.
  - write: mem[a]<=wdata, then RESP.
  - fetch: `ir[31:16]`<=mem[a], then FETCH2.
  - reserved: no memory effect, then RESP with `err`.
- **FETCH2.** `ir[15:0]`<=mem[(a+1) mod DEPTH], then RESP. The address wraps; last word is followed by word 0.
- **RESP.** `ready`=1 for exactly this one cycle. Next state is IDLE if `cs`=0, else HOLD.
- **HOLD.** Waits for `cs`=0, then goes to IDLE. This prevents a held `cs` from re-issuing the same request.
- Latched operands govern the whole transaction. Changes on `sel`/`addr`/`wdata` after acceptance are ignored.
- Dropping `cs` mid-transaction does not abort it. The access completes and `ready` still pulses.
- `ready`, `err` and `busy` are registered outputs, with no combinational path from inputs.
- The memory array is not cleared by reset. Contents survive a reset.
- **Reset mid-transaction:** state goes to IDLE and outputs clear. An in-flight write that has not reached ACCESS is not performed. A fetch interrupted in FETCH2 leaves `ir` at 0.
- **Reset values:** `ready`=0, `err`=0, `busy`=0, `rdata`=0, `ir`=0.

## Timing
- Edge 0 is the first rising edge with IDLE and `cs`=1.
- **Read, write, reserved:** ACCESS is entered at edge `WAIT_STATES`+… specifically, ACCESS executes at edge `WAIT_STATES`+1. `ready` is high for the cycle following that edge.
  - Latency: `WAIT_STATES`+1 edges; the request occupies `WAIT_STATES`+2 cycles.
- **Fetch:** one extra cycle. `ready` is high after edge `WAIT_STATES`+2.
- **Back-to-back requests:** `cs` must be low for at least one sampled edge after `ready`. With `cs` low during RESP, a new request is accepted on the second edge after `ready` rises.
- `busy` rises after edge 0. It falls on the edge that enters IDLE.
- `rdata`/`ir` update on the same edge that raises `ready`. For a fetch, `ir[31:16]` updates one edge earlier.

## Test plan
- **Reset state:** with `reset`=0, all outputs are 0. Release `reset`, idle 5 cycles; all outputs stay 0 and `busy`=0.
- **Write then read, `WAIT_STATES`=1:** write 16'hA5C3 to addr 16'h0012. `ready` pulses after edge 2 with `err`=0. Drop `cs`, read 16'h0012: `rdata`=16'hA5C3 with `ready` after edge 2.
- **Fetch with wrap, `DEPTH`=256:** preload mem[255]=16'h1234 and mem[0]=16'h5678. Fetch addr 16'h01FF (upper bits ignored): `ir`=32'h12345678, `ready` after edge 3.
- **Held `cs`:** keep `cs`=1 for 10 cycles on a read. Exactly one `ready` pulse occurs and `busy` stays 1 (HOLD) until `cs` drops. Then `busy`=0 on the next edge.
- **Reserved op and mid-transaction changes:** `sel`=11 gives `ready`=`err`=1 for one cycle and memory is unchanged. Start a write and change `wdata` and `addr` during WAIT: the originally latched address receives the originally latched data.
- **Reset mid-write:** assert `reset` low while in WAIT. Outputs clear asynchronously and the target word keeps its old value. After release, a read returns the old value.
